alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Control-unit sequencer for a simple register/ALU datapath. It fetches an
// instruction (T0..T2), decodes the opcode held in the IR, and drives the
// datapath strobes for the execute steps (T3..T6). Every output except
// o_pc_in is a registered Moore output of the current state.
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined   -> mul/div opcodes execute over T3..T6 (lo_in, hi_in, z_high_out)
//   undefined -> mul/div opcodes are illegal; hi_in/lo_in/z_high_out tied 0
//
// Ports
//   i_clk                  system clock, rising edge
//   i_reset                synchronous active-high reset
//   i_run                  level: fetch/execute back to back while high
//   i_mem_rdy              memory read data valid this cycle
//   i_ir[31:0]             IR contents: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   o_pc_out .. o_lo_in    datapath strobes (active high)
//   o_gpr_in[15:0]         one-hot register write select
//   o_gpr_out[15:0]        one-hot register read select
//   o_alu_op[3:0]          ALU op: And0 Or1 Add2 Sub3 Shr4 Shl5 Ror6 Rol7
//                          Mul8 Div9 Neg10 Not11
//   o_done                 pulse in the last execute state
//   o_illegal              sticky, set on an unsupported opcode
//   o_state[3:0]           state encoding for debug
// ---------------------------------------------------------------------------
module alu_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_mem_rdy,
    input  logic [31:0] i_ir,
    output logic        o_pc_out,
    output logic        o_pc_in,
    output logic        o_inc_pc,
    output logic        o_mar_in,
    output logic        o_read,
    output logic        o_mdr_in,
    output logic        o_mdr_out,
    output logic        o_ir_in,
    output logic        o_y_in,
    output logic        o_z_in,
    output logic        o_z_low_out,
    output logic        o_z_high_out,
    output logic        o_hi_in,
    output logic        o_lo_in,
    output logic [15:0] o_gpr_in,
    output logic [15:0] o_gpr_out,
    output logic [3:0]  o_alu_op,
    output logic        o_done,
    output logic        o_illegal,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    // Instruction classes
    localparam logic [2:0] CLS_BIN  = 3'd0;
    localparam logic [2:0] CLS_UN   = 3'd1;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [2:0] CLS_MD   = 3'd2;
`endif
    localparam logic [2:0] CLS_HALT = 3'd3;

    localparam logic [3:0] ALU_ADD = 4'd2;

    function automatic logic [2:0] f_cls(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: f_cls = CLS_BIN;
`ifdef ALU_SEQ_MULDIV_EN
            5'b01110, 5'b01111:                     f_cls = CLS_MD;
`endif
            5'b10000, 5'b10001:                     f_cls = CLS_UN;
            5'b11011:                               f_cls = CLS_HALT;
            default:                                f_cls = 3'd4; // illegal
        endcase
    endfunction

    function automatic logic [3:0] f_alu(input logic [4:0] op);
        case (op)
            5'b00011: f_alu = 4'd2;
            5'b00100: f_alu = 4'd3;
            5'b00101: f_alu = 4'd4;
            5'b00110: f_alu = 4'd5;
            5'b00111: f_alu = 4'd6;
            5'b01000: f_alu = 4'd7;
            5'b01001: f_alu = 4'd0;
            5'b01010: f_alu = 4'd1;
            5'b01110: f_alu = 4'd8;
            5'b01111: f_alu = 4'd9;
            5'b10000: f_alu = 4'd10;
            5'b10001: f_alu = 4'd11;
            default:  f_alu = 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] f_onehot(input logic [3:0] idx);
        f_onehot = 16'd1 << idx;
    endfunction

    state_t      r_state;
    logic [16:0] r_ir;          // ir[31:15] captured on entry to T3
    logic        r_pc_out, r_inc_pc, r_mar_in, r_read, r_mdr_in;
    logic        r_mdr_out, r_ir_in, r_y_in, r_z_in, r_z_low_out;
    logic [15:0] r_gpr_in, r_gpr_out;
    logic [3:0]  r_alu_op;
    logic        r_done, r_illegal;
`ifdef ALU_SEQ_MULDIV_EN
    logic        r_z_high_out, r_hi_in, r_lo_in;
`endif

    logic [2:0]  w_cls;
    logic [14:0] w_unused_ir_lsbs;

    assign w_cls            = f_cls(r_ir[16:12]);
    assign w_unused_ir_lsbs = i_ir[14:0];

    // Single FSM block: each branch sets the next state together with the
    // strobes that belong to that next state, so outputs line up with
    // r_state. Strobes default to 0 every cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_pc_out    <= 1'b0;
            r_inc_pc    <= 1'b0;
            r_mar_in    <= 1'b0;
            r_read      <= 1'b0;
            r_mdr_in    <= 1'b0;
            r_mdr_out   <= 1'b0;
            r_ir_in     <= 1'b0;
            r_y_in      <= 1'b0;
            r_z_in      <= 1'b0;
            r_z_low_out <= 1'b0;
            r_gpr_in    <= '0;
            r_gpr_out   <= '0;
            r_alu_op    <= '0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_z_high_out <= 1'b0;
            r_hi_in      <= 1'b0;
            r_lo_in      <= 1'b0;
`endif
        end else begin
            r_pc_out    <= 1'b0;
            r_inc_pc    <= 1'b0;
            r_mar_in    <= 1'b0;
            r_read      <= 1'b0;
            r_mdr_in    <= 1'b0;
            r_mdr_out   <= 1'b0;
            r_ir_in     <= 1'b0;
            r_y_in      <= 1'b0;
            r_z_in      <= 1'b0;
            r_z_low_out <= 1'b0;
            r_gpr_in    <= '0;
            r_gpr_out   <= '0;
            r_alu_op    <= '0;
            r_done      <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_z_high_out <= 1'b0;
            r_hi_in      <= 1'b0;
            r_lo_in      <= 1'b0;
`endif
            // r_done marks the last execute state of any instruction, so
            // it doubles as the "instruction finished" condition.
            if (r_done || r_state == S_IDLE) begin
                if (i_run) begin
                    r_state  <= S_T0;
                    r_pc_out <= 1'b1;
                    r_mar_in <= 1'b1;
                    r_inc_pc <= 1'b1;
                    r_z_in   <= 1'b1;
                    r_alu_op <= ALU_ADD;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_T0: begin
                        r_state     <= S_T1;
                        r_z_low_out <= 1'b1;
                        r_read      <= 1'b1;
                        r_mdr_in    <= 1'b1;
                    end
                    S_T1: begin
                        if (i_mem_rdy) begin
                            r_state   <= S_T2;
                            r_mdr_out <= 1'b1;
                            r_ir_in   <= 1'b1;
                        end else begin
                            r_state     <= S_T1;
                            r_z_low_out <= 1'b1;
                            r_read      <= 1'b1;
                            r_mdr_in    <= 1'b1;
                        end
                    end
                    S_T2: begin
                        // The T3 strobes depend on the instruction, so the
                        // IR is expected to present the fetched word here.
                        r_state <= S_T3;
                        r_ir    <= i_ir[31:15];
                        case (f_cls(i_ir[31:27]))
                            CLS_BIN: begin
                                r_gpr_out <= f_onehot(i_ir[22:19]);
                                r_y_in    <= 1'b1;
                            end
`ifdef ALU_SEQ_MULDIV_EN
                            CLS_MD: begin
                                r_gpr_out <= f_onehot(i_ir[26:23]);
                                r_y_in    <= 1'b1;
                            end
`endif
                            CLS_UN: begin
                                r_gpr_out <= f_onehot(i_ir[22:19]);
                                r_alu_op  <= f_alu(i_ir[31:27]);
                                r_z_in    <= 1'b1;
                            end
                            default: ; // halt / illegal: no strobes in T3
                        endcase
                    end
                    S_T3: begin
                        case (w_cls)
                            CLS_BIN: begin
                                r_state   <= S_T4;
                                r_gpr_out <= f_onehot(r_ir[3:0]);
                                r_alu_op  <= f_alu(r_ir[16:12]);
                                r_z_in    <= 1'b1;
                            end
`ifdef ALU_SEQ_MULDIV_EN
                            CLS_MD: begin
                                r_state   <= S_T4;
                                r_gpr_out <= f_onehot(r_ir[7:4]);
                                r_alu_op  <= f_alu(r_ir[16:12]);
                                r_z_in    <= 1'b1;
                            end
`endif
                            CLS_UN: begin
                                r_state     <= S_T4;
                                r_z_low_out <= 1'b1;
                                r_gpr_in    <= f_onehot(r_ir[11:8]);
                                r_done      <= 1'b1;
                            end
                            CLS_HALT: r_state <= S_HALT;
                            default: begin
                                r_state   <= S_HALT;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                    S_T4: begin
                        // Unary ops finish in T4 and are handled by r_done.
`ifdef ALU_SEQ_MULDIV_EN
                        if (w_cls == CLS_MD) begin
                            r_state     <= S_T5;
                            r_z_low_out <= 1'b1;
                            r_lo_in     <= 1'b1;
                        end else
`endif
                        begin
                            r_state     <= S_T5;
                            r_z_low_out <= 1'b1;
                            r_gpr_in    <= f_onehot(r_ir[11:8]);
                            r_done      <= 1'b1;
                        end
                    end
`ifdef ALU_SEQ_MULDIV_EN
                    S_T5: begin
                        r_state      <= S_T6;
                        r_z_high_out <= 1'b1;
                        r_hi_in      <= 1'b1;
                        r_done       <= 1'b1;
                    end
`endif
                    S_HALT:  r_state <= S_HALT;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // PC load must happen exactly once, in the T1 cycle whose read completes,
    // so it is qualified by the live mem_rdy rather than registered.
    assign o_pc_in      = (r_state == S_T1) && i_mem_rdy;

    assign o_pc_out     = r_pc_out;
    assign o_inc_pc     = r_inc_pc;
    assign o_mar_in     = r_mar_in;
    assign o_read       = r_read;
    assign o_mdr_in     = r_mdr_in;
    assign o_mdr_out    = r_mdr_out;
    assign o_ir_in      = r_ir_in;
    assign o_y_in       = r_y_in;
    assign o_z_in       = r_z_in;
    assign o_z_low_out  = r_z_low_out;
`ifdef ALU_SEQ_MULDIV_EN
    assign o_z_high_out = r_z_high_out;
    assign o_hi_in      = r_hi_in;
    assign o_lo_in      = r_lo_in;
`else
    assign o_z_high_out = 1'b0;
    assign o_hi_in      = 1'b0;
    assign o_lo_in      = 1'b0;
`endif
    assign o_gpr_in     = r_gpr_in;
    assign o_gpr_out    = r_gpr_out;
    assign o_alu_op     = r_alu_op;
    assign o_done       = r_done;
    assign o_illegal    = r_illegal;
    assign o_state      = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. Each step advances one clock and compares
// the full output picture {state, strobes, gpr_in, gpr_out, alu_op, done,
// illegal} against hand-computed values. Mul expectations follow the
// ALU_SEQ_MULDIV_EN macro.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic        clk;
    logic        reset, run, mem_rdy;
    logic [31:0] ir;
    logic        pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
    logic [15:0] gpr_in, gpr_out;
    logic [3:0]  alu_op;
    logic        done, illegal;
    logic [3:0]  state;

    int n_vec = 0;
    int n_err = 0;

    // Strobe bit positions in the packed comparison vector
    localparam logic [13:0] PC_OUT = 14'h2000, PC_IN  = 14'h1000;
    localparam logic [13:0] INC_PC = 14'h0800, MAR_IN = 14'h0400;
    localparam logic [13:0] READ   = 14'h0200, MDR_IN = 14'h0100;
    localparam logic [13:0] MDR_OUT= 14'h0080, IR_IN  = 14'h0040;
    localparam logic [13:0] Y_IN   = 14'h0020, Z_IN   = 14'h0010;
    localparam logic [13:0] Z_LOW  = 14'h0008, Z_HIGH = 14'h0004;
    localparam logic [13:0] HI_IN  = 14'h0002, LO_IN  = 14'h0001;
    localparam logic [13:0] NONE   = 14'h0000;

    localparam logic [13:0] SB_T0 = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [13:0] SB_T1 = Z_LOW | READ | MDR_IN;
    localparam logic [13:0] SB_T2 = MDR_OUT | IR_IN;

    // Instruction words: op Ra Rb Rc
    localparam logic [31:0] IR_SHL  = 32'h32920000; // shl  Ra=5 Rb=2 Rc=4
    localparam logic [31:0] IR_ADD  = 32'h18918000; // add  Ra=1 Rb=2 Rc=3
    localparam logic [31:0] IR_NEG  = 32'h83380000; // neg  Ra=6 Rb=7
    localparam logic [31:0] IR_MUL  = 32'h71A00000; // mul  Ra=3 Rb=4
    localparam logic [31:0] IR_ILL  = 32'hF8000000; // opcode 11111
    localparam logic [31:0] IR_HALT = 32'hD8000000; // opcode 11011

    logic [13:0] sb;
    assign sb = {pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
                 y_in, z_in, z_low_out, z_high_out, hi_in, lo_in};

    alu_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_run        (run),
        .i_mem_rdy    (mem_rdy),
        .i_ir         (ir),
        .o_pc_out     (pc_out),
        .o_pc_in      (pc_in),
        .o_inc_pc     (inc_pc),
        .o_mar_in     (mar_in),
        .o_read       (read),
        .o_mdr_in     (mdr_in),
        .o_mdr_out    (mdr_out),
        .o_ir_in      (ir_in),
        .o_y_in       (y_in),
        .o_z_in       (z_in),
        .o_z_low_out  (z_low_out),
        .o_z_high_out (z_high_out),
        .o_hi_in      (hi_in),
        .o_lo_in      (lo_in),
        .o_gpr_in     (gpr_in),
        .o_gpr_out    (gpr_out),
        .o_alu_op     (alu_op),
        .o_done       (done),
        .o_illegal    (illegal),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs for the new cycle are driven after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [3:0] st,
                       input logic [13:0] esb, input logic [15:0] egi,
                       input logic [15:0] ego, input logic [3:0] ealu,
                       input logic edn, input logic eil);
        logic [55:0] obs;
        logic [55:0] exp;
        #1;
        obs = {state, sb, gpr_in, gpr_out, alu_op, done, illegal};
        exp = {st, esb, egi, ego, ealu, edn, eil};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch from IDLE or a finished instruction with run=1 and mem_rdy=1.
    task automatic fetch(input string tag);
        cyc(); chk({tag, "_t0"}, 4'd1, SB_T0, 16'h0, 16'h0, 4'd2, 1'b0, 1'b0);
        cyc(); chk({tag, "_t1"}, 4'd2, SB_T1 | PC_IN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk({tag, "_t2"}, 4'd3, SB_T2, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; mem_rdy = 1'b1; ir = IR_SHL;
        cyc(); cyc();
        chk("reset_run_ignored", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Shl, back-to-back execution
        fetch("shl");
        cyc(); chk("shl_t3", 4'd4, Y_IN,  16'h0000, 16'h0004, 4'd0, 1'b0, 1'b0);
        cyc(); chk("shl_t4", 4'd5, Z_IN,  16'h0000, 16'h0010, 4'd5, 1'b0, 1'b0);
        cyc(); chk("shl_t5", 4'd6, Z_LOW, 16'h0020, 16'h0000, 4'd0, 1'b1, 1'b0);

        // Add with three wait cycles in T1, reset in T4
        cyc(); ir = IR_ADD; mem_rdy = 1'b0;
        chk("add_t0", 4'd1, SB_T0, 16'h0, 16'h0, 4'd2, 1'b0, 1'b0);
        cyc(); chk("wait_1", 4'd2, SB_T1, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("wait_2", 4'd2, SB_T1, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("wait_3", 4'd2, SB_T1, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); mem_rdy = 1'b1;
        chk("wait_4_rdy", 4'd2, SB_T1 | PC_IN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("add_t2", 4'd3, SB_T2, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("add_t3", 4'd4, Y_IN, 16'h0, 16'h0004, 4'd0, 1'b0, 1'b0);
        cyc(); reset = 1'b1;
        chk("add_t4", 4'd5, Z_IN, 16'h0, 16'h0008, 4'd2, 1'b0, 1'b0);
        cyc(); chk("reset_at_t4", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); run = 1'b0;
        chk("reset_hold", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        // mem_rdy is high here; it must not disturb IDLE or raise pc_in
        cyc(); chk("idle_mem_rdy", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

        // Add again, run dropped during T4
        run = 1'b1;
        fetch("add2");
        cyc(); chk("add2_t3", 4'd4, Y_IN, 16'h0, 16'h0004, 4'd0, 1'b0, 1'b0);
        cyc(); run = 1'b0;
        chk("add2_t4", 4'd5, Z_IN, 16'h0, 16'h0008, 4'd2, 1'b0, 1'b0);
        cyc(); chk("add2_t5", 4'd6, Z_LOW, 16'h0002, 16'h0, 4'd0, 1'b1, 1'b0);
        cyc(); chk("add2_idle", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("idle_stay", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

        // Neg (unary, T5 skipped), then straight into mul
        ir = IR_NEG; run = 1'b1;
        fetch("neg");
        cyc(); chk("neg_t3", 4'd4, Z_IN, 16'h0, 16'h0080, 4'd10, 1'b0, 1'b0);
        cyc(); chk("neg_t4", 4'd5, Z_LOW, 16'h0040, 16'h0, 4'd0, 1'b1, 1'b0);
        cyc(); ir = IR_MUL;
        chk("mul_t0", 4'd1, SB_T0, 16'h0, 16'h0, 4'd2, 1'b0, 1'b0);
        cyc(); chk("mul_t1", 4'd2, SB_T1 | PC_IN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("mul_t2", 4'd3, SB_T2, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
`ifdef ALU_SEQ_MULDIV_EN
        cyc(); chk("mul_t3", 4'd4, Y_IN, 16'h0, 16'h0008, 4'd0, 1'b0, 1'b0);
        cyc(); chk("mul_t4", 4'd5, Z_IN, 16'h0, 16'h0010, 4'd8, 1'b0, 1'b0);
        cyc(); run = 1'b0;
        chk("mul_t5", 4'd6, Z_LOW | LO_IN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("mul_t6", 4'd7, Z_HIGH | HI_IN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        cyc(); chk("mul_idle", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
`else
        cyc(); chk("mul_t3_ill", 4'd4, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("mul_halt", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
        cyc(); chk("mul_halt_hold", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
`endif
        reset = 1'b1;
        cyc(); chk("mul_reset", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0; run = 1'b1; ir = IR_ILL;

        // Illegal opcode 11111
        fetch("ill");
        cyc(); chk("ill_t3", 4'd4, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("ill_halt", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
        cyc(); chk("ill_halt_hold", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(); chk("ill_reset", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0; ir = IR_HALT;

        // Halt opcode 11011
        fetch("halt");
        cyc(); chk("halt_t3", 4'd4, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("halt_state", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        cyc(); chk("halt_hold", 4'd8, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(); chk("halt_reset", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0; run = 1'b0;
        cyc(); chk("final_idle", 4'd0, NONE, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
